// File: rtl/seq_chunk_adder_pkg.sv
// Shared state and mode encodings for the chunked sequential adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/ripple_adder_n.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_full_adder
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry held in a register
// between chunks, start/busy/done handshake.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_c;

  always_comb begin
    chunk_a = opa_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_b = opb_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  ripple_adder_n #(.N(CHUNK)) u_ripple (
    .x    (chunk_a),
    .y    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b once here, seed carry with 1.
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = (sub == MODE_SUB);
          idx_d   = '0;
          msb_a_d = a[WIDTH-1];
          msb_b_d = b[WIDTH-1] ^ sub;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        work_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_s;
        carry_d = chunk_c;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          sum_d   = work_d;
          cout_d  = chunk_c;
          ovf_d   = (msb_a_q == msb_b_q) && (work_d[WIDTH-1] != msb_a_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised-width adder/subtractor. It processes operands CHUNK bits per clock through a CHUNK-bit ripple stage and carries between chunks in a register. It trades latency for a short combinational path, sits between the operand registers and the display/ALU logic, and replaces fixed 4-bit ripple adders where wide operands are needed. A start/busy/done handshake controls each operation, and a mode bit selects subtraction.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived number of RUN cycles; localparam, not overridable

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  first operand, unsigned or two's complement
b  input  WIDTH  second operand
busy  output  1  high while the operation is in progress (RUN)
done  output  1  one-cycle pulse; results valid and updated
sum  output  WIDTH  result register
cout  output  1  carry out; for sub, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal index, carry and operand registers=0.
- States:
  - IDLE: busy=0, done=0. On an edge with start=1, latch opa=a, opb=b XOR {WIDTH{sub}}, carry=sub, idx=0, msb_a=a[WIDTH-1], msb_b=opb[WIDTH-1]. Go to RUN.
  - RUN: busy=1. Each edge adds chunk idx as opa[idx*CHUNK +: CHUNK] + opb[same] + carry. Write the chunk result into the working register, update carry with the chunk carry-out, and increment idx.
  - Edge with idx==NCHUNK-1: copy the complete working result to sum, set cout=chunk carry-out, and set ovf=(msb_a==msb_b) && (result MSB != msb_a). Go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0. Next edge goes to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge E0, chunks computed at E1..E_NCHUNK, done high in the cycle after E_NCHUNK. With the defaults, done is high 4 cycles after acceptance. Minimum initiation interval is NCHUNK+2 cycles.
- Result holding: sum, cout and ovf change only on the final RUN edge. They hold the previous result through IDLE and RUN until the next operation completes.
- start while busy or in DONE: ignored, no queuing.
- a, b and sub may change freely after acceptance; the block uses the latched copies only.
- Reset mid-RUN: abort immediately to reset values; no done pulse.
- Width rules: all internal adds are CHUNK+1 bits wide; the inter-chunk carry is 1 bit. Arithmetic wraps modulo 2^WIDTH.
- With CHUNK==WIDTH, RUN lasts exactly one cycle.

Decomposition:
- Shared package/include seq_adder_defs: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the mode encoding MODE_ADD=0, MODE_SUB=1.
- One sub-module, ripple_adder_n (parameter N=CHUNK), is natural. It is a combinational N-bit ripple chain of full_adder cells: inputs x, y, cin; outputs s, cout.
- The top module holds only the FSM, the registers and the chunk multiplexing.

Test Plan:
- Basic add: WIDTH=16, CHUNK=4, a=0x1234, b=0x4321, sub=0. Required: busy high for 4 cycles, done one cycle later, sum=0x5555, cout=0, ovf=0.
- Carry chain across all chunks: a=0xFFFF, b=0x0001, add. Required: sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001. Required: sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1. Required: sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1. Required: sum=0x7FFF, cout=1, ovf=1.
- Handshake: pulse start again during RUN and during DONE with different operands. Required: ignored, first result unchanged, exactly one done pulse. Changing a/b mid-RUN must not affect sum.
- Reset mid-operation: assert rst after 2 RUN cycles. Required: outputs zero immediately, no done pulse. A new start after deassert gives a correct result.
- Parameter sweep: CHUNK=16 (1-cycle RUN) and CHUNK=1 (16-cycle RUN), 1000 random a/b/sub each. Required: sum, cout and ovf match a reference model.
